// File: rtl/exe_hazard_ctrl.sv
// EXE-stage hazard sequencer: load-use stalls, taken-branch flushes and multi-cycle mul holds,
// plus saturating stall/flush event counters.
module exe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic [4:0]       exe_d,
  input  logic             exe_mul,
  input  logic             exe_condition_jmp,
  output logic             wpcir,
  output logic             ide_en,
  output logic             bubble,
  output logic             exe_bubble,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  // The RUN cycle and the final MUL_WAIT cycle are each one stall, so the
  // counter covers only the MUL_WAIT cycles in between (MUL_LAT-1 stalls total).
  localparam logic [CW-1:0] CNT_LOAD = (MUL_LAT > 2) ? CW'(MUL_LAT - 3) : '0;
  localparam logic          MUL_EN   = 1'(MUL_LAT > 1);
  localparam logic          MUL_LONG = 1'(MUL_LAT > 2);

  typedef enum logic [1:0] {RUN = 2'd0, MUL_WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lu_haz;
  logic          mul_go;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  assign lu_haz = exe_m2reg & exe_wreg & (exe_d != 5'd0) &
                  ((id_use_rs & (id_rs == exe_d)) | (id_use_rt & (id_rt == exe_d)));
  assign mul_go = exe_mul & MUL_EN;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (!exe_condition_jmp && mul_go) begin
          if (MUL_LONG) begin
            state_nxt = MUL_WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      MUL_WAIT: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Outputs fall back to free-flow values while clrn is low, independent of the clock.
  always_comb begin
    wpcir      = 1'b1;
    ide_en     = 1'b1;
    bubble     = 1'b0;
    exe_bubble = 1'b0;
    flush_ifid = 1'b0;
    if (clrn) begin
      if (state == MUL_WAIT) begin
        wpcir      = 1'b0;
        ide_en     = 1'b0;
        exe_bubble = 1'b1;
      end else if (exe_condition_jmp) begin
        flush_ifid = 1'b1;
        bubble     = 1'b1;
      end else if ((state == RUN) && mul_go) begin
        wpcir      = 1'b0;
        ide_en     = 1'b0;
        exe_bubble = 1'b1;
      end else if (lu_haz) begin
        wpcir  = 1'b0;
        bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      stall_cycles <= sat_inc(stall_cycles, ~wpcir);
      flush_count  <= sat_inc(flush_count, flush_ifid);
    end
  end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Bench for exe_hazard_ctrl: three instances (MUL_LAT 4/2/1) on shared inputs, each checked
// against a cycle-level model built from the hazard rules.
module tb_exe_hazard_ctrl;

  localparam int LATS [3] = '{4, 2, 1};
  localparam int CMAX [3] = '{65535, 15, 15};

  logic       clk = 1'b0;
  logic       clrn;
  logic [4:0] id_rs, id_rt, exe_d;
  logic       id_use_rs, id_use_rt, exe_wreg, exe_m2reg, exe_mul, exe_condition_jmp;

  // ctl = {wpcir, ide_en, bubble, exe_bubble, flush_ifid}
  logic [4:0]  ctl     [3];
  logic [15:0] stall_o [3];
  logic [15:0] flush_o [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 0) ? 16 : 4;
    logic          w, ie, b, eb, fl;
    logic [CW-1:0] sc, fc;
    exe_hazard_ctrl #(.MUL_LAT(LATS[g]), .CNT_W(CW)) u_dut (
      .clk(clk), .clrn(clrn),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_d(exe_d), .exe_mul(exe_mul),
      .exe_condition_jmp(exe_condition_jmp),
      .wpcir(w), .ide_en(ie), .bubble(b), .exe_bubble(eb), .flush_ifid(fl),
      .stall_cycles(sc), .flush_count(fc)
    );
    assign ctl[g]     = {w, ie, b, eb, fl};
    assign stall_o[g] = 16'(sc);
    assign flush_o[g] = 16'(fc);
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining stall cycles of a mul, and whether this cycle is the mul's release cycle.
  int         m_rem   [3];
  bit         m_done  [3];
  int         m_stall [3];
  int         m_flush [3];
  logic [4:0] exp_ctl [3];
  int         exp_stall [3];
  int         exp_flush [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_rem[k] = 0; m_done[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  task automatic zero_inputs();
    id_rs = 0; id_rt = 0; exe_d = 0; id_use_rs = 0; id_use_rt = 0;
    exe_wreg = 0; exe_m2reg = 0; exe_mul = 0; exe_condition_jmp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    zero_inputs();
    clrn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
  endtask

  // Drives one cycle of inputs at the falling edge and computes the expected outputs for it.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] d,
                      input bit urs, input bit urt, input bit wreg, input bit m2reg,
                      input bit mul, input bit jmp);
    bit lu;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_stall[k] = m_stall[k];
      exp_flush[k] = m_flush[k];
    end
    id_rs = rs; id_rt = rt; exe_d = d; id_use_rs = urs; id_use_rt = urt;
    exe_wreg = wreg; exe_m2reg = m2reg; exe_mul = mul; exe_condition_jmp = jmp;
    #1;
    lu = m2reg && wreg && (d != 0) && ((urs && rs == d) || (urt && rt == d));
    for (int k = 0; k < 3; k++) begin
      logic [4:0] e;
      bit         done_n;
      e = 5'b11000;
      done_n = 0;
      if (m_rem[k] > 0) begin
        e = 5'b00010;
        m_rem[k]--;
        done_n = (m_rem[k] == 0);
      end else if (jmp) begin
        e = 5'b11101;
      end else if (!m_done[k] && mul && LATS[k] > 1) begin
        e = 5'b00010;
        m_rem[k] = LATS[k] - 2;
        done_n = (m_rem[k] == 0);
      end else if (lu) begin
        e = 5'b01100;
      end
      m_done[k]  = done_n;
      exp_ctl[k] = e;
      if (!e[4] && m_stall[k] < CMAX[k]) m_stall[k]++;
      if (e[0] && m_flush[k] < CMAX[k]) m_flush[k]++;
    end
  endtask

  task automatic step_idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    zero_inputs();
    exe_mul = 1'b1; exe_condition_jmp = 1'b1;
    clrn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== 5'b11000) begin
        failures++; $display("FAIL reset_ctl dut%0d got=%b exp=%b", k, ctl[k], 5'b11000);
      end
      checks++;
      if (stall_o[k] !== 16'd0 || flush_o[k] !== 16'd0) begin
        failures++; $display("FAIL reset_cnt dut%0d got=%0d/%0d exp=0/0", k, stall_o[k], flush_o[k]);
      end
    end
    @(negedge clk);
    zero_inputs();
    clrn = 1'b1;
    model_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    step(5'd5, 5'd7, 5'd5, 1, 1, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== exp_ctl[k] || ctl[k] !== 5'b01100) begin
        failures++; $display("FAIL load_use_ctl dut%0d got=%b exp=%b", k, ctl[k], exp_ctl[k]);
      end
    end
    step_idle();
    checks++;
    if (ctl[0] !== 5'b11000) begin
      failures++; $display("FAIL load_use_release got=%b exp=%b", ctl[0], 5'b11000);
    end
    checks++;
    if (stall_o[0] !== 16'd1 || stall_o[0] !== 16'(exp_stall[0])) begin
      failures++; $display("FAIL load_use_stall_cnt got=%0d exp=1", stall_o[0]);
    end
  endtask

  task automatic test_r0();
    do_reset();
    step(5'd0, 5'd0, 5'd0, 1, 1, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== 5'b11000) begin
        failures++; $display("FAIL r0_no_stall dut%0d got=%b exp=%b", k, ctl[k], 5'b11000);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    step(5'd9, 5'd9, 5'd9, 1, 0, 1, 1, 0, 1);
    checks++;
    if (ctl[0] !== 5'b11101) begin
      failures++; $display("FAIL branch_over_lu got=%b exp=%b", ctl[0], 5'b11101);
    end
    step(5'd3, 5'd4, 5'd2, 0, 0, 0, 0, 1, 1);
    checks++;
    if (ctl[0] !== 5'b11101 || ctl[0] !== exp_ctl[0]) begin
      failures++; $display("FAIL branch_over_mul got=%b exp=%b", ctl[0], 5'b11101);
    end
    step_idle();
    checks++;
    if (flush_o[0] !== 16'd2 || stall_o[0] !== 16'd0) begin
      failures++; $display("FAIL branch_counts got=%0d/%0d exp=2/0", flush_o[0], stall_o[0]);
    end
  endtask

  task automatic test_mul();
    logic [4:0] want [4];
    want = '{5'b00010, 5'b00010, 5'b00010, 5'b11000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (ctl[0] !== want[i]) begin
        failures++; $display("FAIL mul_lat4 cyc%0d got=%b exp=%b", i, ctl[0], want[i]);
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (ctl[k] !== exp_ctl[k]) begin
          failures++; $display("FAIL mul_short dut%0d cyc%0d got=%b exp=%b", k, i, ctl[k], exp_ctl[k]);
        end
      end
    end
    checks++;
    if (ctl[2] !== 5'b11000) begin
      failures++; $display("FAIL mul_lat1_no_stall got=%b exp=%b", ctl[2], 5'b11000);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ctl[k] !== exp_ctl[k]) begin
          failures++; $display("FAIL b2b_ctl dut%0d cyc%0d got=%b exp=%b", k, i, ctl[k], exp_ctl[k]);
        end
      end
    end
    step_idle();
    checks++;
    if (stall_o[0] !== 16'd6) begin
      failures++; $display("FAIL b2b_stall_cnt got=%0d exp=6", stall_o[0]);
    end
    checks++;
    if (stall_o[1] !== 16'(exp_stall[1]) || stall_o[1] !== 16'd4) begin
      failures++; $display("FAIL b2b_lat2_cnt got=%0d exp=4", stall_o[1]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ctl[k] !== exp_ctl[k]) begin
          failures++; $display("FAIL rand_ctl dut%0d cyc%0d got=%b exp=%b", k, i, ctl[k], exp_ctl[k]);
        end
        checks++;
        if (stall_o[k] !== 16'(exp_stall[k]) || flush_o[k] !== 16'(exp_flush[k])) begin
          failures++;
          $display("FAIL rand_cnt dut%0d cyc%0d got=%0d/%0d exp=%0d/%0d", k, i,
                   stall_o[k], flush_o[k], exp_stall[k], exp_flush[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #2;
    zero_inputs();
    clrn = 1'b0;
    #1;
    checks++;
    if (ctl[0] !== 5'b11000) begin
      failures++; $display("FAIL mid_mul_reset_ctl got=%b exp=%b", ctl[0], 5'b11000);
    end
    checks++;
    if (stall_o[0] !== 16'd0) begin
      failures++; $display("FAIL mid_mul_reset_cnt got=%0d exp=0", stall_o[0]);
    end
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
    step_idle();
    checks++;
    if (ctl[0] !== 5'b11000) begin
      failures++; $display("FAIL mid_mul_dropped got=%b exp=%b", ctl[0], 5'b11000);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) step(5'd6, 5'd0, 5'd6, 1, 0, 1, 1, 0, 0);
    step_idle();
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (stall_o[k] !== 16'h000F) begin
        failures++; $display("FAIL stall_saturate dut%0d got=%h exp=%h", k, stall_o[k], 16'h000F);
      end
    end
    checks++;
    if (stall_o[0] !== 16'd20) begin
      failures++; $display("FAIL stall_wide_cnt got=%0d exp=20", stall_o[0]);
    end
  endtask

  initial begin
    clrn = 1'b1;
    zero_inputs();
    model_reset();
    test_reset();
    test_load_use();
    test_r0();
    test_branch();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
